pong_display_scheduler: RTL and testbench
=========================================

# pong_display_scheduler

Time-multiplexes the 8x8 LED matrix of the ping-pong game between three sources: player-1 paddle (row 7), player-2 paddle (row 0) and the ball pixel. Owns both paddle position registers, updates them from single-cycle button pulses with saturation, and snapshots all display content at frame start so a frame never tears. Sits between the game logic (button pulses, ball coordinates) and the matrix pin drivers (Sx column drive, active-high; Sy row drive, active-low).

## Interface
- SLOT_CYCLES, default 1000: clock cycles per display slot; legal range ≥2.
- BLANK_CYCLES, default 50: leading blank cycles at the start of every slot (anti-ghosting); legal range 0..SLOT_CYCLES-1.
- CNT_W, default 16: width of the slot counter; must hold SLOT_CYCLES-1.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- en  in  1  scan enable.
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  single-cycle button pulses (already debounced).
- ball_x  in  3  ball column.
- ball_y  in  3  ball row.
- ball_on  in  1  ball visible.
- Sx  out  8  column drive, one bit per column, 1 = lit.
- Sy  out  8  row drive, 0 = row selected.
- slot  out  2  slot whose pattern is on Sx/Sy: 0 = P1, 1 = P2, 2 = BALL.
- p1_pos, p2_pos  out  3 each  live paddle positions (leftmost lit column).
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Paddle positions: range 0..5, since a paddle covers columns pos, pos+1, pos+2. An up pulse increments the position and saturates at 5. A down pulse decrements it and saturates at 0. Up and down in the same cycle leave it unchanged. The update is visible on p1_pos/p2_pos the next cycle. Buttons are accepted regardless of en.
- Shadow registers s1, s2, sbx, sby, sbon load from p1_pos, p2_pos, ball_x, ball_y, ball_on when either of these holds:
  - en=0
  - slot state = BALL and cnt = SLOT_CYCLES-1
- The display always uses the shadow registers.
- Slot FSM: P1 → P2 → BALL → P1. cnt counts 0..SLOT_CYCLES-1 within each slot. When cnt = SLOT_CYCLES-1, the FSM advances to the next slot and cnt returns to 0.
- Pattern for the current state and cnt:
  - cnt < BLANK_CYCLES: Sx=00, Sy=FF.
  - P1: Sx bits s1..s1+2 set, Sy=7F.
  - P2: Sx bits s2..s2+2 set, Sy=FE.
  - BALL with sbon=1: Sx one-hot at sbx; Sy all ones except bit sby = 0.
  - BALL with sbon=0: Sx=00, Sy=FF.
- en=0: FSM forced to P1 with cnt=0, outputs blank, frame_done=0. When en returns to 1, the frame starts at P1, cnt=0.

## Timing
- Reset values:
  - Sx=00, Sy=FF, slot=0, frame_done=0
  - p1_pos=2, p2_pos=2, shadows equal to those values with sbon=0
  - FSM in P1, cnt=0
- All outputs are registered. Sx, Sy and slot reflect the (state, cnt) of the previous cycle, so there is one cycle of latency.
- frame_done is high for exactly one cycle, the cycle after BALL with cnt = SLOT_CYCLES-1. The frame period is 3*SLOT_CYCLES cycles.
- The slot output changes on the same edge as the first blank cycle of the new slot.
- Reset asserted mid-frame: every register returns to its reset value immediately (asynchronous). The first frame after rst_n deasserts starts at P1, cnt=0, provided en=1.
- en dropping mid-slot: Sx=00, Sy=FF on the next edge. Position pulses arriving in that same cycle are still applied.

## Test plan
All scenarios use SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset: with rst_n low and no clock edge, read the outputs → Sx=00, Sy=FF, slot=0, p1_pos=p2_pos=2, frame_done=0.
- Full frame with ball (3,5,on), en rising at cycle 0:
  - Cycles 1–2: blank, slot=0.
  - Cycles 3–8: Sx=1C, Sy=7F.
  - Cycles 9–10: blank, slot=1. Cycles 11–16: Sx=1C, Sy=FE.
  - Cycles 17–18: blank, slot=2. Cycles 19–24: Sx=08, Sy=DF.
  - frame_done pulses once, at cycle 24; the next frame starts at slot 0.
- Saturation:
  - 4 p1_up pulses → p1_pos=5 (never 6); the next frame's P1 shows Sx=E0.
  - Then 7 p1_dn pulses → p1_pos=0; the next frame shows Sx=07.
- Simultaneous events: p2_up and p2_dn together → p2_pos unchanged. p1_up together with p2_dn → both paddles update independently.
- Snapshot: change p1_pos and ball_x during slot P2 → the rest of the frame keeps the old pattern; the new values appear only from the next frame. With ball_on=0 at frame start, BALL shows Sx=00, Sy=FF.
- Mid-operation abort:
  - en low during BALL → blank and slot=0 on the next cycle, no frame_done. Re-enable restarts at P1.
  - Async rst_n pulse mid-slot → reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/pong_display_scheduler_if.sv
// Game-side and matrix-side signals of the pong display scheduler.
// The slave modport is the scheduler's view. The master modport is the game/driver view.
interface pong_display_scheduler_if;
   logic       en;
   logic       p1_up;
   logic       p1_dn;
   logic       p2_up;
   logic       p2_dn;
   logic [2:0] ball_x;
   logic [2:0] ball_y;
   logic       ball_on;
   logic [7:0] Sx;
   logic [7:0] Sy;
   logic [1:0] slot;
   logic [2:0] p1_pos;
   logic [2:0] p2_pos;
   logic       frame_done;

   modport master (
      output en, p1_up, p1_dn, p2_up, p2_dn, ball_x, ball_y, ball_on,
      input  Sx, Sy, slot, p1_pos, p2_pos, frame_done
   );

   modport slave (
      input  en, p1_up, p1_dn, p2_up, p2_dn, ball_x, ball_y, ball_on,
      output Sx, Sy, slot, p1_pos, p2_pos, frame_done
   );
endinterface

// File: rtl/pong_display_scheduler.sv
// Time-multiplexes the 8x8 pong matrix between the P1 paddle, the P2 paddle and the ball.
// Paddle registers live here. All display content is snapshotted at frame start, so a frame never tears.
module pong_display_scheduler #(
   parameter int SLOT_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 50,
   parameter int CNT_W        = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   pong_display_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_P1   = 2'd0,
      ST_P2   = 2'd1,
      ST_BALL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [2:0]       POS_MAX   = 3'd5;
   localparam logic [2:0]       POS_RESET = 3'd2;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       s1;
   logic [2:0]       s2;
   logic [2:0]       sbx;
   logic [2:0]       sby;
   logic             sbon;
   logic [7:0]       nxt_sx;
   logic [7:0]       nxt_sy;
   logic             slot_end;
   logic             snap;

   // A paddle spans pos..pos+2, so its position saturates at 0..5. Opposing pulses cancel.
   function automatic logic [2:0] step_pos(input logic [2:0] pos, input logic up, input logic dn);
      step_pos = pos;
      if (up && !dn && pos != POS_MAX)
         step_pos = pos + 3'd1;
      else if (dn && !up && pos != 3'd0)
         step_pos = pos - 3'd1;
   endfunction

   assign slot_end = (cnt == CNT_LAST);
   assign snap     = !bus.en || (state == ST_BALL && slot_end);

   // NOTE: every output of this block gets a default first. This keeps any path from leaving a value held, so no latch can be inferred.
   always_comb begin
      nxt_sx = 8'h00;
      nxt_sy = 8'hFF;
      if (cnt >= CNT_BLANK) begin
         case (state)
            ST_P1: begin
               nxt_sx = 8'b0000_0111 << s1;
               nxt_sy = 8'h7F;
            end
            ST_P2: begin
               nxt_sx = 8'b0000_0111 << s2;
               nxt_sy = 8'hFE;
            end
            ST_BALL: begin
               if (sbon) begin
                  nxt_sx = 8'b0000_0001 << sbx;
                  nxt_sy = ~(8'b0000_0001 << sby);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: all state below is updated with non-blocking assignments. Every register then samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.p1_pos <= POS_RESET;
         bus.p2_pos <= POS_RESET;
      end else begin
         bus.p1_pos <= step_pos(bus.p1_pos, bus.p1_up, bus.p1_dn);
         bus.p2_pos <= step_pos(bus.p2_pos, bus.p2_up, bus.p2_dn);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= POS_RESET;
         s2   <= POS_RESET;
         sbx  <= 3'd0;
         sby  <= 3'd0;
         sbon <= 1'b0;
      end else if (snap) begin
         s1   <= bus.p1_pos;
         s2   <= bus.p2_pos;
         sbx  <= bus.ball_x;
         sby  <= bus.ball_y;
         sbon <= bus.ball_on;
      end
   end

   // Slot FSM with registered outputs. The outputs trail (state, cnt) by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_P1;
         cnt            <= '0;
         bus.Sx         <= 8'h00;
         bus.Sy         <= 8'hFF;
         bus.slot       <= 2'd0;
         bus.frame_done <= 1'b0;
      end else if (!bus.en) begin
         state          <= ST_P1;
         cnt            <= '0;
         bus.Sx         <= 8'h00;
         bus.Sy         <= 8'hFF;
         bus.slot       <= 2'd0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.Sx         <= nxt_sx;
         bus.Sy         <= nxt_sy;
         bus.slot       <= state;
         bus.frame_done <= (state == ST_BALL) && slot_end;
         if (slot_end) begin
            cnt <= '0;
            case (state)
               ST_P1:   state <= ST_P2;
               ST_P2:   state <= ST_BALL;
               default: state <= ST_P1;
            endcase
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pong_display_scheduler.sv
// Directed bench for pong_display_scheduler with SLOT_CYCLES=8 and BLANK_CYCLES=2.
// Cycle c means the c-th rising edge after en is raised, sampled 1 time unit after that edge.
module tb_pong_display_scheduler;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   pong_display_scheduler_if bus ();

   pong_display_scheduler #(
      .SLOT_CYCLES  (8),
      .BLANK_CYCLES (2),
      .CNT_W        (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with en low reloads the shadows and parks the FSM. On return, the bench is at cycle 0.
   task automatic restart_frame();
      bus.en = 1'b0;
      tick();
      bus.en = 1'b1;
   endtask

   task automatic check_pat(input string tag, input logic [7:0] sx, input logic [7:0] sy);
      check({tag, " Sx"}, 32'(bus.Sx), 32'(sx));
      check({tag, " Sy"}, 32'(bus.Sy), 32'(sy));
   endtask

   logic [2:0] up_exp [4] = '{3'd3, 3'd4, 3'd5, 3'd5};
   logic [2:0] dn_exp [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};

   initial begin
      logic [7:0] e_sx;
      logic [7:0] e_sy;
      logic [1:0] e_slot;
      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b1;
      bus.en      = 1'b0;
      bus.p1_up   = 1'b0;
      bus.p1_dn   = 1'b0;
      bus.p2_up   = 1'b0;
      bus.p2_dn   = 1'b0;
      bus.ball_x  = 3'd3;
      bus.ball_y  = 3'd5;
      bus.ball_on = 1'b1;

      // Reset is applied before the first clock edge, so these values come only from the asynchronous reset.
      #1 rst_n = 1'b0;
      #1;
      check("rst Sx", 32'(bus.Sx), 32'h00);
      check("rst Sy", 32'(bus.Sy), 32'hFF);
      check("rst slot", 32'(bus.slot), 0);
      check("rst p1_pos", 32'(bus.p1_pos), 2);
      check("rst p2_pos", 32'(bus.p2_pos), 2);
      check("rst frame_done", 32'(bus.frame_done), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Full frame with the ball at (3,5) and lit.
      bus.en = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         e_slot = (c <= 8) ? 2'd0 : (c <= 16) ? 2'd1 : (c <= 24) ? 2'd2 : 2'd0;
         if (c inside {1, 2, 9, 10, 17, 18, 25}) begin
            e_sx = 8'h00; e_sy = 8'hFF;
         end else if (e_slot == 2'd0) begin
            e_sx = 8'h1C; e_sy = 8'h7F;
         end else if (e_slot == 2'd1) begin
            e_sx = 8'h1C; e_sy = 8'hFE;
         end else begin
            e_sx = 8'h08; e_sy = 8'hDF;
         end
         check_pat($sformatf("frame c%0d", c), e_sx, e_sy);
         check($sformatf("frame c%0d slot", c), 32'(bus.slot), 32'(e_slot));
         check($sformatf("frame c%0d frame_done", c), 32'(bus.frame_done), (c == 24) ? 1 : 0);
      end

      // Saturation of p1_pos at 5, then at 0.
      for (int i = 0; i < 4; i++) begin
         bus.p1_up = 1'b1;
         tick();
         bus.p1_up = 1'b0;
         check($sformatf("sat up %0d p1_pos", i), 32'(bus.p1_pos), 32'(up_exp[i]));
      end
      restart_frame();
      repeat (3) tick();
      check_pat("sat pos5 P1", 8'hE0, 8'h7F);
      for (int i = 0; i < 7; i++) begin
         bus.p1_dn = 1'b1;
         tick();
         bus.p1_dn = 1'b0;
         check($sformatf("sat dn %0d p1_pos", i), 32'(bus.p1_pos), 32'(dn_exp[i]));
      end
      restart_frame();
      repeat (3) tick();
      check_pat("sat pos0 P1", 8'h07, 8'h7F);

      // Simultaneous pulses.
      bus.p2_up = 1'b1;
      bus.p2_dn = 1'b1;
      tick();
      bus.p2_up = 1'b0;
      bus.p2_dn = 1'b0;
      check("both p2 p2_pos", 32'(bus.p2_pos), 2);
      bus.p1_up = 1'b1;
      bus.p2_dn = 1'b1;
      tick();
      bus.p1_up = 1'b0;
      bus.p2_dn = 1'b0;
      check("p1up p2dn p1_pos", 32'(bus.p1_pos), 1);
      check("p1up p2dn p2_pos", 32'(bus.p2_pos), 1);

      // Snapshot: p1_pos and the ball change during P2, which only affects the next frame.
      restart_frame();
      for (int c = 1; c <= 48; c++) begin
         tick();
         if (c >= 3 && c <= 8)   check_pat($sformatf("snap c%0d", c), 8'h0E, 8'h7F);
         if (c >= 11 && c <= 16) check_pat($sformatf("snap c%0d", c), 8'h0E, 8'hFE);
         if (c >= 19 && c <= 24) check_pat($sformatf("snap c%0d", c), 8'h08, 8'hDF);
         if (c >= 27 && c <= 32) check_pat($sformatf("snap c%0d", c), 8'h1C, 8'h7F);
         if (c >= 35 && c <= 40) check_pat($sformatf("snap c%0d", c), 8'h0E, 8'hFE);
         if (c >= 43 && c <= 48) check_pat($sformatf("snap c%0d", c), 8'h00, 8'hFF);
         if (c == 13) check("snap live p1_pos", 32'(bus.p1_pos), 2);
         if (c == 24) check("snap frame_done", 32'(bus.frame_done), 1);
         if (c == 12) begin
            bus.p1_up   = 1'b1;
            bus.ball_x  = 3'd6;
            bus.ball_on = 1'b0;
         end else begin
            bus.p1_up = 1'b0;
         end
      end

      // en dropped during BALL, then re-enabled.
      bus.ball_x  = 3'd3;
      bus.ball_on = 1'b1;
      restart_frame();
      repeat (19) tick();
      check_pat("abort pre BALL", 8'h08, 8'hDF);
      check("abort pre slot", 32'(bus.slot), 2);
      bus.en = 1'b0;
      tick();
      check_pat("abort off", 8'h00, 8'hFF);
      check("abort off slot", 32'(bus.slot), 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("abort off %0d frame_done", i), 32'(bus.frame_done), 0);
      end
      bus.en = 1'b1;
      tick();
      check_pat("abort re c1", 8'h00, 8'hFF);
      check("abort re c1 slot", 32'(bus.slot), 0);
      repeat (2) tick();
      check_pat("abort re c3", 8'h1C, 8'h7F);
      check("abort re c3 slot", 32'(bus.slot), 0);

      // Asynchronous reset pulse mid-slot.
      bus.p1_up = 1'b1;
      tick();
      bus.p1_up = 1'b0;
      check("arst pre p1_pos", 32'(bus.p1_pos), 3);
      restart_frame();
      repeat (12) tick();
      check_pat("arst pre P2", 8'h0E, 8'hFE);
      #2 rst_n = 1'b0;
      #1;
      check_pat("arst", 8'h00, 8'hFF);
      check("arst slot", 32'(bus.slot), 0);
      check("arst p1_pos", 32'(bus.p1_pos), 2);
      check("arst p2_pos", 32'(bus.p2_pos), 2);
      check("arst frame_done", 32'(bus.frame_done), 0);
      #1 rst_n = 1'b1;
      tick();
      check_pat("arst post c1", 8'h00, 8'hFF);
      check("arst post c1 slot", 32'(bus.slot), 0);
      repeat (2) tick();
      check_pat("arst post c3", 8'h1C, 8'h7F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
